mem_write_tracer: RTL

Synthesizable, parametrised monitor on the CPU data-memory write port. It sits beside `DataMemoryManager` and taps `data_mem_address`, `data_mem_in_data` and `data_mem_WE` without driving them. Each write is classified into one of N address regions, such as the data region and the output-image region. Matching writes are buffered in a trace FIFO that a host, UART bridge or bench drains through a valid/ready port, and per-region write counters and overflow status are kept alongside.

---
 rtl/mem_trace_pkg.sv | 29 ++
 rtl/mem_write_tracer_fifo.sv | 50 +++++
 rtl/mem_write_tracer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mem_trace_pkg.sv
// Shared types and helpers for the data-memory write tracer.
// The stamp field of trace_entry_t exists only when TRACE_STAMP_EN is defined.
package mem_trace_pkg;

    localparam int unsigned IMG_OUT_BASE = 262144;
    localparam int unsigned DATA_LIMIT   = 4095;

    // Entry fields are sized for the widest supported configuration (8 regions, 32-bit address/data/stamp).
    localparam int ENTRY_RW      = 3;
    localparam int ENTRY_ADDR_W  = 32;
    localparam int ENTRY_DATA_W  = 32;
    localparam int ENTRY_STAMP_W = 32;

    typedef struct packed {
`ifdef TRACE_STAMP_EN
        logic [ENTRY_STAMP_W-1:0] stamp;
`endif
        logic [ENTRY_RW-1:0]      region;
        logic [ENTRY_ADDR_W-1:0]  offset;
        logic [ENTRY_DATA_W-1:0]  data;
    } trace_entry_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mem_write_tracer_fifo.sv
// Synchronous FIFO of trace entries; storage is cleared on reset so the head reads zero.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module trace_fifo
    import mem_trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  trace_entry_t             push_entry_i,
    input  logic                     pop_i,
    output trace_entry_t             head_o,
    output logic                     valid_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int PW = $clog2(DEPTH);

    trace_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   level_q;
    logic          do_pop;
    logic          do_push;

    assign valid_o = (level_q != '0);
    assign full_o  = (level_q == (PW+1)'(DEPTH));
    assign do_pop  = pop_i && valid_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_entry_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/mem_write_tracer.sv
// Passive tracer on the data-memory write port: classifies writes by region, queues them, counts them.
// Optional per-entry cycle stamp enabled by defining TRACE_STAMP_EN.
module mem_write_tracer
    import mem_trace_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int N_REGIONS = 2,
    parameter int DEPTH     = 16,
    parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE  = {ADDR_W'(IMG_OUT_BASE), ADDR_W'(0)},
    parameter logic [N_REGIONS*ADDR_W-1:0] REGION_LIMIT = {{ADDR_W{1'b1}}, ADDR_W'(DATA_LIMIT)},
    parameter int CNT_W     = 16,
    parameter int STAMP_W   = 32,
    localparam int RW       = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [ADDR_W-1:0]           data_mem_address_i,
    input  logic [DATA_W-1:0]           data_mem_in_data_i,
    input  logic                        data_mem_WE_i,
    input  logic                        trace_en_i,
    input  logic                        clear_i,
    output logic                        trace_valid_o,
    input  logic                        trace_ready_i,
    output logic [RW-1:0]               trace_region_o,
    output logic [ADDR_W-1:0]           trace_offset_o,
    output logic [DATA_W-1:0]           trace_data_o,
`ifdef TRACE_STAMP_EN
    output logic [STAMP_W-1:0]          trace_stamp_o,
`endif
    output logic [N_REGIONS*CNT_W-1:0]  region_count_o,
    output logic [CNT_W-1:0]            unmatched_count_o,
    output logic [CNT_W-1:0]            dropped_count_o,
    output logic                        overflow_o,
    output logic [$clog2(DEPTH):0]      level_o
);
    logic              capture;
    logic              hit;
    logic [RW-1:0]     hit_idx;
    logic [ADDR_W-1:0] hit_base;
    logic              pop;
    logic              fifo_full;
    trace_entry_t      push_entry;
    trace_entry_t      head;

    logic [CNT_W-1:0]  region_cnt_q [N_REGIONS];
    logic [CNT_W-1:0]  region_cnt_d [N_REGIONS];
    logic [CNT_W-1:0]  unmatched_q, unmatched_d;
    logic [CNT_W-1:0]  dropped_q, dropped_d;
    logic              overflow_q, overflow_d;

    assign capture = data_mem_WE_i && trace_en_i && !clear_i;
    assign pop     = trace_valid_o && trace_ready_i;

    // Scan from the top down so the lowest-indexed matching region is the one left standing.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_base = '0;
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            if (data_mem_address_i >= REGION_BASE[i*ADDR_W +: ADDR_W] &&
                data_mem_address_i <= REGION_LIMIT[i*ADDR_W +: ADDR_W]) begin
                hit      = 1'b1;
                hit_idx  = RW'(i);
                hit_base = REGION_BASE[i*ADDR_W +: ADDR_W];
            end
        end
    end

`ifdef TRACE_STAMP_EN
    logic [STAMP_W-1:0] stamp_q;

    always_ff @(posedge CLK) begin
        if (RST || clear_i) stamp_q <= '0;
        else                stamp_q <= stamp_q + 1'b1;
    end

    assign trace_stamp_o = head.stamp[STAMP_W-1:0];
`else
    localparam logic [31:0] UNUSED_STAMP_W = 32'(STAMP_W);
`endif

    always_comb begin
        push_entry        = '0;
        push_entry.region = ENTRY_RW'(hit_idx);
        push_entry.offset = ENTRY_ADDR_W'(data_mem_address_i - hit_base);
        push_entry.data   = ENTRY_DATA_W'(data_mem_in_data_i);
`ifdef TRACE_STAMP_EN
        push_entry.stamp  = ENTRY_STAMP_W'(stamp_q);
`endif
    end

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i        (CLK),
        .rst_i        (RST || clear_i),
        .push_i       (capture && hit),
        .push_entry_i (push_entry),
        .pop_i        (trace_ready_i),
        .head_o       (head),
        .valid_o      (trace_valid_o),
        .full_o       (fifo_full),
        .level_o      (level_o)
    );

    assign trace_region_o = head.region[RW-1:0];
    assign trace_offset_o = head.offset[ADDR_W-1:0];
    assign trace_data_o   = head.data[DATA_W-1:0];

    logic unused_head;
    assign unused_head = ^head;

    always_comb begin
        region_cnt_d = region_cnt_q;
        unmatched_d  = unmatched_q;
        dropped_d    = dropped_q;
        overflow_d   = overflow_q;
        if (capture) begin
            if (hit) begin
                region_cnt_d[hit_idx] = CNT_W'(sat_inc(32'(region_cnt_q[hit_idx]), CNT_W));
                if (fifo_full && !pop) begin
                    dropped_d  = CNT_W'(sat_inc(32'(dropped_q), CNT_W));
                    overflow_d = 1'b1;
                end
            end else begin
                unmatched_d = CNT_W'(sat_inc(32'(unmatched_q), CNT_W));
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || clear_i) begin
            region_cnt_q <= '{default: '0};
            unmatched_q  <= '0;
            dropped_q    <= '0;
            overflow_q   <= 1'b0;
        end else begin
            region_cnt_q <= region_cnt_d;
            unmatched_q  <= unmatched_d;
            dropped_q    <= dropped_d;
            overflow_q   <= overflow_d;
        end
    end

    always_comb begin
        region_count_o = '0;
        for (int i = 0; i < N_REGIONS; i++) region_count_o[i*CNT_W +: CNT_W] = region_cnt_q[i];
    end

    assign unmatched_count_o = unmatched_q;
    assign dropped_count_o   = dropped_q;
    assign overflow_o        = overflow_q;

endmodule
